mux2_16b: RTL and testbench

Two-input, 16-bit word multiplexer used on the datapath to choose between two 16-bit sources (e.g. register-file output vs. immediate). Output `Y` is purely combinational from `A`, `B` and `control`. A clocked side path provides a registered copy of the selected word, the registered select, and a saturating count of select changes for debug and performance observation.

---
 rtl/mux2_16b.sv | 69 ++++++
 tb/tb_mux2_16b.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_16b.sv
// mux2_16b: 16-bit 2:1 word mux with a registered copy, registered select and saturating switch counter.
// Define MUX2_16B_PARITY_EN to add par_q, the even parity of Y_q.
module mux2_16b #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             control,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_q,
  output logic             sel_q,
  output logic [CNT_W-1:0] sw_cnt
`ifdef MUX2_16B_PARITY_EN
  ,
  output logic             par_q
`endif
);

  logic [WIDTH-1:0] w_y;
  logic             w_changed;
  logic             w_cnt_max;

  logic [WIDTH-1:0] r_y_q;
  logic             r_sel_q;
  logic [CNT_W-1:0] r_sw_cnt;

  // Ternary keeps an unknown select visible as X in simulation.
  assign w_y       = control ? B : A;
  assign w_changed = (control != r_sel_q);
  assign w_cnt_max = &r_sw_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y_q    <= '0;
      r_sel_q  <= 1'b0;
      r_sw_cnt <= '0;
    end else begin
      r_y_q   <= w_y;
      r_sel_q <= control;
      if (w_changed && !w_cnt_max) begin
        r_sw_cnt <= r_sw_cnt + 1'b1;
      end
    end
  end

`ifdef MUX2_16B_PARITY_EN
  logic r_par_q;

  // Parity is taken from Y so it lines up with Y_q on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_par_q <= 1'b0;
    end else begin
      r_par_q <= ^w_y;
    end
  end

  assign par_q = r_par_q;
`endif

  assign Y      = w_y;
  assign Y_q    = r_y_q;
  assign sel_q  = r_sel_q;
  assign sw_cnt = r_sw_cnt;

endmodule

// File: tb/tb_mux2_16b.sv
// tb_mux2_16b: scoreboard bench for mux2_16b; a monitor checks the registered side path every cycle.
// Build with MUX2_16B_PARITY_EN defined to also cover par_q.
module tb_mux2_16b;

  logic        clk;
  logic        clkRun;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic        control;
  logic [15:0] Y;
  logic [15:0] Y_q;
  logic        sel_q;
  logic [7:0]  sw_cnt;
`ifdef MUX2_16B_PARITY_EN
  logic        par_q;
`endif

  typedef struct packed {
    logic [15:0] y;
    logic        sel;
    logic [7:0]  cnt;
  } expT;

  expT  sbQ[$];
  logic mSel;
  logic [7:0] mCnt;
  int   checks;
  int   errors;

  mux2_16b #(.WIDTH(16), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (A),
    .B       (B),
    .control (control),
    .Y       (Y),
    .Y_q     (Y_q),
    .sel_q   (sel_q),
    .sw_cnt  (sw_cnt)
`ifdef MUX2_16B_PARITY_EN
    ,
    .par_q   (par_q)
`endif
  );

  always begin
    #5;
    if (clkRun) clk = ~clk;
  end

  // Monitor pops one expectation per edge; reset edges push nothing.
  always begin
    expT e;
    @(posedge clk);
    #1;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checks++;
      if (Y_q !== e.y) begin
        errors++;
        $display("[TB] FAIL sb_yq: got %h expected %h", Y_q, e.y);
      end
      checks++;
      if (sel_q !== e.sel) begin
        errors++;
        $display("[TB] FAIL sb_sel: got %b expected %b", sel_q, e.sel);
      end
      checks++;
      if (sw_cnt !== e.cnt) begin
        errors++;
        $display("[TB] FAIL sb_cnt: got %0d expected %0d", sw_cnt, e.cnt);
      end
`ifdef MUX2_16B_PARITY_EN
      checks++;
      if (par_q !== ^e.y) begin
        errors++;
        $display("[TB] FAIL sb_par: got %b expected %b", par_q, ^e.y);
      end
`endif
    end
  end

  // Drives one cycle of inputs, pushes the model's prediction, then steps past the edge.
  task automatic runCycle(input logic [15:0] a, input logic [15:0] b, input logic c);
    expT e;
    A       = a;
    B       = b;
    control = c;
    e.y   = c ? b : a;
    e.sel = c;
    e.cnt = ((c != mSel) && (mCnt != 8'hFF)) ? mCnt + 8'd1 : mCnt;
    mSel  = c;
    mCnt  = e.cnt;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_comb_sweep();
    logic [15:0] exp;
    for (int c = 0; c < 2; c++) begin
      for (int a = 0; a < 2; a++) begin
        for (int b = 2; b < 4; b++) begin
          A       = 16'(a);
          B       = 16'(b);
          control = 1'(c);
          #1;
          exp = (c == 1) ? 16'(b) : 16'(a);
          checks++;
          if (Y !== exp) begin
            errors++;
            $display("[TB] FAIL comb_sweep: got %h expected %h (c=%0d a=%0d b=%0d)", Y, exp, c, a, b);
          end
        end
      end
    end
  endtask

  task automatic test_toggle_extremes();
    logic [15:0] expSeq [3];
    logic        ctlSeq [3];
    expSeq = '{16'hFFFF, 16'h0000, 16'hFFFF};
    ctlSeq = '{1'b0, 1'b1, 1'b0};
    A = 16'hFFFF;
    B = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      control = ctlSeq[i];
      #1;
      checks++;
      if (Y !== expSeq[i]) begin
        errors++;
        $display("[TB] FAIL toggle_extremes[%0d]: got %h expected %h", i, Y, expSeq[i]);
      end
    end
  endtask

  task automatic test_reset();
    A       = 16'h1234;
    B       = 16'hBEEF;
    control = 1'b0;
    rst_n   = 1'b0;
    clkRun  = 1'b1;
    @(posedge clk);
    #1;
    mSel = 1'b0;
    mCnt = 8'd0;
    checks++;
    if (Y_q !== 16'h0000) begin errors++; $display("[TB] FAIL reset_yq: got %h expected 0000", Y_q); end
    checks++;
    if (sel_q !== 1'b0) begin errors++; $display("[TB] FAIL reset_sel: got %b expected 0", sel_q); end
    checks++;
    if (sw_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", sw_cnt); end
    checks++;
    if (Y !== 16'h1234) begin errors++; $display("[TB] FAIL reset_y_live: got %h expected 1234", Y); end
`ifdef MUX2_16B_PARITY_EN
    checks++;
    if (par_q !== 1'b0) begin errors++; $display("[TB] FAIL reset_par: got %b expected 0", par_q); end
`endif
    rst_n = 1'b1;
    runCycle(16'h1234, 16'hBEEF, 1'b0);
    checks++;
    if (Y_q !== 16'h1234) begin errors++; $display("[TB] FAIL release_yq: got %h expected 1234", Y_q); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      runCycle(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      runCycle(16'($urandom), 16'($urandom), ~mSel);
    end
    checks++;
    if (sw_cnt !== 8'hFF) begin errors++; $display("[TB] FAIL saturate: got %0d expected 255", sw_cnt); end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    mSel  = 1'b0;
    mCnt  = 8'd0;
    rst_n = 1'b1;
    checks++;
    if (sw_cnt !== 8'd0) begin errors++; $display("[TB] FAIL saturate_reset: got %0d expected 0", sw_cnt); end
  endtask

  task automatic test_first_edge();
    runCycle(16'hAAAA, 16'h5555, 1'b1);
    checks++;
    if (sw_cnt !== 8'd1) begin errors++; $display("[TB] FAIL first_edge_cnt: got %0d expected 1", sw_cnt); end
    runCycle(16'hAAAA, 16'h5555, 1'b1);
    checks++;
    if (sw_cnt !== 8'd1) begin errors++; $display("[TB] FAIL hold_cnt: got %0d expected 1", sw_cnt); end
  endtask

`ifdef MUX2_16B_PARITY_EN
  task automatic test_parity();
    runCycle(16'h0000, 16'h0007, 1'b1);
    checks++;
    if (par_q !== 1'b1) begin errors++; $display("[TB] FAIL parity_odd: got %b expected 1", par_q); end
    runCycle(16'h0000, 16'h0003, 1'b1);
    checks++;
    if (par_q !== 1'b0) begin errors++; $display("[TB] FAIL parity_even: got %b expected 0", par_q); end
  endtask
`endif

  initial begin
    clk     = 1'b0;
    clkRun  = 1'b0;
    rst_n   = 1'b0;
    A       = 16'h0000;
    B       = 16'h0000;
    control = 1'b0;
    mSel    = 1'b0;
    mCnt    = 8'd0;
    checks  = 0;
    errors  = 0;

    test_comb_sweep();
    test_toggle_extremes();
    test_reset();
    test_back_to_back();
    test_saturate();
    test_first_edge();
`ifdef MUX2_16B_PARITY_EN
    test_parity();
`endif

    #2;
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain: got %0d pending expected 0", sbQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
